// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock,
// with optional signed input and dash/blank display sentinel codes.
module bcd_seq_converter #(
  parameter int WIDTH     = 7,
  parameter int DIGITS    = 3,
  parameter int SIGNED    = 0,
  parameter int SENTINELS = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  busy,
  output logic                  done,
  output logic                  valid
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SPECIAL
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    dig;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    dig_sh;
  logic [BW-1:0]    fill;
  logic             sign;
  logic             sign_q;
  logic             neg_q;
  logic             is_dash;
  logic             is_blank;
  logic             is_sent;
  logic             last;

  // Sentinels are matched on the raw pattern, ahead of sign handling
  assign is_dash  = (SENTINELS != 0) && (binary == '1);
  assign is_blank = (SENTINELS != 0) &&
                    (binary == {{(WIDTH-1){1'b1}}, 1'b0});
  assign is_sent  = is_dash | is_blank;

  assign sign = (SIGNED != 0) && binary[WIDTH-1];
  assign mag  = sign ? (~binary + WIDTH'(1)) : binary;

  always_comb begin
    fill = '0;
    adj  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      fill[4*k +: 4] = is_dash ? 4'hA : 4'hB;
      adj[4*k +: 4]  = (dig[4*k +: 4] >= 4'd5) ?
                       dig[4*k +: 4] + 4'd3 :
                       dig[4*k +: 4];
    end
  end

  // Digits and shift register move as one chain
  assign dig_sh = {adj[BW-2:0], sr[WIDTH-1]};
  assign last   = (cnt == CW'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = is_sent ? SPECIAL : SHIFT;
      SHIFT:   if (last)  state_n = IDLE;
      SPECIAL: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      sr     <= '0;
      dig    <= '0;
      sign_q <= 1'b0;
      bcd    <= '0;
      neg_q  <= 1'b0;
      valid  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (is_sent) begin
            dig    <= fill;
            sign_q <= 1'b0;
          end else begin
            sr     <= mag;
            dig    <= '0;
            cnt    <= CW'(WIDTH);
            sign_q <= sign;
          end
        end
      end else if (state == SHIFT) begin
        sr  <= {sr[WIDTH-2:0], 1'b0};
        dig <= dig_sh;
        cnt <= cnt - CW'(1);
        if (last) begin
          bcd   <= dig_sh;
          neg_q <= sign_q;
          valid <= 1'b1;
          done  <= 1'b1;
        end
      end else if (state == SPECIAL) begin
        bcd   <= dig;
        neg_q <= 1'b0;
        valid <= 1'b1;
        done  <= 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign negative = (SIGNED != 0) && neg_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed scoreboard bench for bcd_seq_converter: an unsigned
// instance with sentinels and a signed 8-bit instance.
module tb_bcd_seq_converter;

  logic        clk;
  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic [6:0]  bin_a;
  logic [7:0]  bin_b;
  logic [11:0] bcd_a;
  logic [11:0] bcd_b;
  logic        neg_a, busy_a, done_a, valid_a;
  logic        neg_b, busy_b, done_b, valid_b;

  logic        sel;
  logic [11:0] m_bcd;
  logic        m_neg, m_busy, m_done, m_valid;

  int checks = 0;
  int errors = 0;
  logic [12:0] q[$];

  bcd_seq_converter u_a (
    .clock(clk), .reset_n(rst_n), .start(start_a),
    .binary(bin_a), .bcd(bcd_a), .negative(neg_a),
    .busy(busy_a), .done(done_a), .valid(valid_a)
  );

  bcd_seq_converter #(
    .WIDTH(8), .DIGITS(3), .SIGNED(1), .SENTINELS(0)
  ) u_b (
    .clock(clk), .reset_n(rst_n), .start(start_b),
    .binary(bin_b), .bcd(bcd_b), .negative(neg_b),
    .busy(busy_b), .done(done_b), .valid(valid_b)
  );

  assign m_bcd   = sel ? bcd_b   : bcd_a;
  assign m_neg   = sel ? neg_b   : neg_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_valid = sel ? valid_b : valid_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [7:0] b, input logic [12:0] e);
    if (sel) begin start_b = 1'b1; bin_b = b; end
    else     begin start_a = 1'b1; bin_a = b[6:0]; end
    q.push_back(e);
  endtask

  task automatic fin(input int lat, input int inj, input string tag);
    int n;
    logic [12:0] e;
    n = 0;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    while (m_done !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, 32'(m_busy), 32'd1);
      n++;
      if (n == inj) begin
        if (sel) begin start_b = 1'b1; bin_b = 8'd5; end
        else     begin start_a = 1'b1; bin_a = 7'd5; end
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a   = 7'($urandom);
        bin_b   = 8'($urandom);
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_done"}, 32'(m_done), 32'd1);
    chk({tag, "_idle"}, 32'(m_busy), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_bcd"}, 32'(m_bcd), 32'(e[11:0]));
      chk({tag, "_neg"}, 32'(m_neg), 32'(e[12]));
    end
  endtask

  initial begin
    int hits;
    sel     = 1'b0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bin_a   = '0;
    bin_b   = '0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(bcd_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_neg_b", 32'(neg_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    go(8'd99, {1'b0, 12'h099});  fin(7, -1, "u99");
    @(negedge clk);
    go(8'd100, {1'b0, 12'h100}); fin(7, -1, "u100");
    @(negedge clk);
    go(8'd0, {1'b0, 12'h000});   fin(7, -1, "u0");
    @(negedge clk);
    go(8'd125, {1'b0, 12'h125}); fin(7, -1, "u125");
    @(negedge clk);
    go(8'd127, {1'b0, 12'hAAA}); fin(1, -1, "dash");
    @(negedge clk);
    go(8'd126, {1'b0, 12'hBBB}); fin(1, -1, "blank");
    @(negedge clk);
    go(8'd42, {1'b0, 12'h042});  fin(7, 3, "ign");
    go(8'd17, {1'b0, 12'h017});  fin(7, -1, "b2b");

    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 7'd90;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_valid", 32'(valid_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a === 1'b1) hits++;
    end
    chk("abort_nodone", 32'(hits), 32'd0);
    go(8'd63, {1'b0, 12'h063});  fin(7, -1, "u63");

    sel = 1'b1;
    @(negedge clk);
    go(8'h80, {1'b1, 12'h128});  fin(8, -1, "s80");
    @(negedge clk);
    go(8'hFF, {1'b1, 12'h001});  fin(8, -1, "sFF");
    @(negedge clk);
    go(8'h7F, {1'b0, 12'h127});  fin(8, -1, "s7F");
    @(negedge clk);
    go(8'hFE, {1'b1, 12'h002});  fin(8, -1, "sFE");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
